// File: rtl/image_fifo_burst_arbiter_pkg.sv
// Shared state encoding and sizing helpers for the image FIFO burst arbiter.
package image_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCmd,
    StData
  } arb_state_e;

  // Channel-index width (CH_W); never narrower than one bit.
  function automatic int unsigned ch_w(input int unsigned n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

  // Beat-counter width (BEAT_W).
  function automatic int unsigned beat_w(input int unsigned burst_len);
    return (burst_len > 1) ? $clog2(burst_len) : 1;
  endfunction

endpackage

// File: rtl/image_fifo_burst_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping.
module rr_arbiter import image_arb_pkg::*; #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]       req,
  input  logic [ch_w(N)-1:0] ptr,
  output logic [N-1:0]       gnt_oh,
  output logic [ch_w(N)-1:0] gnt_idx,
  output logic               gnt_any
);

  localparam int unsigned IdxW = ch_w(N);

  logic [IdxW-1:0] idx;

  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = ptr;
    for (int unsigned i = 0; i < N; i++) begin
      if (!gnt_any && req[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = idx;
      end
      idx = (idx == IdxW'(N - 1)) ? '0 : idx + IdxW'(1);
    end
    if (gnt_any) begin
      gnt_oh[gnt_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/image_fifo_burst_arbiter.sv
// Shares one DDR write-burst port between N_CH prefetch FIFOs: round-robin grant,
// one command per burst, then exactly BURST_LEN beats drained from the granted FIFO.
module image_fifo_burst_arbiter import image_arb_pkg::*; #(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned DW          = 32,
  parameter int unsigned BURST_LEN   = 16,
  parameter int unsigned ADDR_W      = 24,
  parameter int unsigned FRAME_BEATS = 1920 * 1080 / 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH-1:0]       src_burst_rdy,
  input  logic [N_CH-1:0]       src_vld,
  input  logic [N_CH*DW-1:0]    src_data,
  output logic [N_CH-1:0]       src_en,
  input  logic [N_CH-1:0]       addr_clr,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic [ch_w(N_CH)-1:0] cmd_ch,
  output logic [ADDR_W-1:0]     cmd_addr,
  output logic                  wr_vld,
  input  logic                  wr_rdy,
  output logic [DW-1:0]         wr_data,
  output logic                  wr_last
);

  localparam int unsigned CH_W   = ch_w(N_CH);
  localparam int unsigned BEAT_W = beat_w(BURST_LEN);
  localparam logic [BEAT_W-1:0] LastBeat  = BEAT_W'(BURST_LEN - 1);
  localparam logic [ADDR_W:0]   BurstStep = (ADDR_W + 1)'(BURST_LEN);
  localparam logic [ADDR_W:0]   FrameEnd  = (ADDR_W + 1)'(FRAME_BEATS);

  arb_state_e        state_q;
  logic [CH_W-1:0]   gnt_q, ptr_q, rr_idx;
  logic [N_CH-1:0]   gnt_oh_q, rr_oh;
  logic              rr_any;
  logic [BEAT_W-1:0] beat_cnt_q;
  logic [ADDR_W-1:0] addr_q [N_CH];
  logic [N_CH-1:0]   clr_pend_q;
  logic [DW-1:0]     src_word [N_CH];
  logic              in_data, beat_fire, burst_end;
  logic [ADDR_W:0]   addr_inc;

  for (genvar c = 0; c < N_CH; c++) begin : g_unpack
    assign src_word[c] = src_data[c*DW +: DW];
  end

  rr_arbiter #(
    .N (N_CH)
  ) u_rr_arbiter (
    .req     (src_burst_rdy),
    .ptr     (ptr_q),
    .gnt_oh  (rr_oh),
    .gnt_idx (rr_idx),
    .gnt_any (rr_any)
  );

  // Data path is a straight pass-through of the granted FIFO so stalls lose nothing.
  assign in_data   = (state_q == StData);
  assign wr_vld    = in_data & src_vld[gnt_q];
  assign wr_data   = in_data ? src_word[gnt_q] : '0;
  assign src_en    = (in_data && wr_rdy) ? gnt_oh_q : '0;
  assign beat_fire = wr_vld & wr_rdy;
  assign wr_last   = wr_vld && (beat_cnt_q == LastBeat);
  assign burst_end = beat_fire && (beat_cnt_q == LastBeat);
  assign addr_inc  = {1'b0, addr_q[gnt_q]} + BurstStep;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      gnt_q      <= '0;
      gnt_oh_q   <= '0;
      ptr_q      <= '0;
      beat_cnt_q <= '0;
      cmd_valid  <= 1'b0;
      cmd_ch     <= '0;
      cmd_addr   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (rr_any) begin
            gnt_q      <= rr_idx;
            gnt_oh_q   <= rr_oh;
            beat_cnt_q <= '0;
            cmd_valid  <= 1'b1;
            cmd_ch     <= rr_idx;
            // A clear landing on the grant cycle zeroes the address this burst uses.
            cmd_addr   <= addr_clr[rr_idx] ? '0 : addr_q[rr_idx];
            state_q    <= StCmd;
          end
        end
        StCmd: begin
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            state_q   <= StData;
          end
        end
        StData: begin
          if (beat_fire) begin
            beat_cnt_q <= beat_cnt_q + BEAT_W'(1);
            if (burst_end) begin
              ptr_q   <= (gnt_q == CH_W'(N_CH - 1)) ? '0 : gnt_q + CH_W'(1);
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Clears on the active channel are deferred to burst end and win over the increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned c = 0; c < N_CH; c++) begin
        addr_q[c] <= '0;
      end
      clr_pend_q <= '0;
    end else begin
      for (int unsigned c = 0; c < N_CH; c++) begin
        if (state_q != StIdle && gnt_q == CH_W'(c)) begin
          if (burst_end) begin
            addr_q[c]     <= (clr_pend_q[c] || addr_clr[c] || addr_inc >= FrameEnd) ?
                             '0 : addr_inc[ADDR_W-1:0];
            clr_pend_q[c] <= 1'b0;
          end else if (addr_clr[c]) begin
            clr_pend_q[c] <= 1'b1;
          end
        end else if (addr_clr[c]) begin
          addr_q[c] <= '0;
        end
      end
    end
  end

endmodule
